// File: rtl/id_hazard_ctrl_pkg.sv
// rtl/id_hazard_ctrl_pkg.sv - shared encodings for the pipeline hazard/trap controller
//
// Purpose: trap FSM state encodings, trap kind codes and the bundle of
//          per-stage control strobes the controller produces each cycle.
// Ports:   none (package).
package id_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_DRAIN    = 2'b01,
        ST_REDIRECT = 2'b10
    } state_e;

    localparam logic [1:0] TRAP_NONE   = 2'b00;
    localparam logic [1:0] TRAP_ECALL  = 2'b01;
    localparam logic [1:0] TRAP_EBREAK = 2'b10;
    localparam logic [1:0] TRAP_MRET   = 2'b11;

    typedef struct packed {
        logic pc_stall;
        logic if2id_stall;
        logic if2id_flush;
        logic id2ex_bubble;
        logic freeze;
        logic trap_redirect;
    } ctrl_t;

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// rtl/id_hazard_ctrl_if.sv - pipeline status inputs and stage control outputs
//
// Purpose: groups the decode-stage usage, stage-register rd/valid state and
//          the per-stage control strobes of id_hazard_ctrl.
// Modports: master - pipeline side (drives status, observes controls)
//           slave  - the controller (observes status, drives controls)
interface id_hazard_ctrl_if #(
    parameter int IDX_W = 5,
    parameter int CNT_W = 64
);
    logic             id_hazard_ctrl_id_valid_i;
    logic             id_hazard_ctrl_id_rs1_en_i;
    logic             id_hazard_ctrl_id_rs2_en_i;
    logic [IDX_W-1:0] id_hazard_ctrl_id_rs1_index_i;
    logic [IDX_W-1:0] id_hazard_ctrl_id_rs2_index_i;
    logic             id_hazard_ctrl_id_jb_i;
    logic             id_hazard_ctrl_id_jb_taken_i;
    logic             id_hazard_ctrl_id_trap_i;
    logic [1:0]       id_hazard_ctrl_id_trap_type_i;
    logic             id_hazard_ctrl_id2ex_valid_i;
    logic             id_hazard_ctrl_id2ex_rd_en_i;
    logic             id_hazard_ctrl_id2ex_load_i;
    logic [IDX_W-1:0] id_hazard_ctrl_id2ex_rd_index_i;
    logic             id_hazard_ctrl_ex2mem_valid_i;
    logic             id_hazard_ctrl_ex2mem_rd_en_i;
    logic             id_hazard_ctrl_ex2mem_load_i;
    logic [IDX_W-1:0] id_hazard_ctrl_ex2mem_rd_index_i;
    logic             id_hazard_ctrl_mem2wb_valid_i;
    logic             id_hazard_ctrl_mem_busy_i;

    logic             id_hazard_ctrl_pc_stall_o;
    logic             id_hazard_ctrl_if2id_stall_o;
    logic             id_hazard_ctrl_if2id_flush_o;
    logic             id_hazard_ctrl_id2ex_bubble_o;
    logic             id_hazard_ctrl_freeze_o;
    logic             id_hazard_ctrl_trap_redirect_o;
    logic [1:0]       id_hazard_ctrl_trap_type_o;
    logic [CNT_W-1:0] id_hazard_ctrl_stall_cnt_o;

    modport master (
        output id_hazard_ctrl_id_valid_i, id_hazard_ctrl_id_rs1_en_i, id_hazard_ctrl_id_rs2_en_i,
               id_hazard_ctrl_id_rs1_index_i, id_hazard_ctrl_id_rs2_index_i,
               id_hazard_ctrl_id_jb_i, id_hazard_ctrl_id_jb_taken_i,
               id_hazard_ctrl_id_trap_i, id_hazard_ctrl_id_trap_type_i,
               id_hazard_ctrl_id2ex_valid_i, id_hazard_ctrl_id2ex_rd_en_i,
               id_hazard_ctrl_id2ex_load_i, id_hazard_ctrl_id2ex_rd_index_i,
               id_hazard_ctrl_ex2mem_valid_i, id_hazard_ctrl_ex2mem_rd_en_i,
               id_hazard_ctrl_ex2mem_load_i, id_hazard_ctrl_ex2mem_rd_index_i,
               id_hazard_ctrl_mem2wb_valid_i, id_hazard_ctrl_mem_busy_i,
        input  id_hazard_ctrl_pc_stall_o, id_hazard_ctrl_if2id_stall_o,
               id_hazard_ctrl_if2id_flush_o, id_hazard_ctrl_id2ex_bubble_o,
               id_hazard_ctrl_freeze_o, id_hazard_ctrl_trap_redirect_o,
               id_hazard_ctrl_trap_type_o, id_hazard_ctrl_stall_cnt_o
    );

    modport slave (
        input  id_hazard_ctrl_id_valid_i, id_hazard_ctrl_id_rs1_en_i, id_hazard_ctrl_id_rs2_en_i,
               id_hazard_ctrl_id_rs1_index_i, id_hazard_ctrl_id_rs2_index_i,
               id_hazard_ctrl_id_jb_i, id_hazard_ctrl_id_jb_taken_i,
               id_hazard_ctrl_id_trap_i, id_hazard_ctrl_id_trap_type_i,
               id_hazard_ctrl_id2ex_valid_i, id_hazard_ctrl_id2ex_rd_en_i,
               id_hazard_ctrl_id2ex_load_i, id_hazard_ctrl_id2ex_rd_index_i,
               id_hazard_ctrl_ex2mem_valid_i, id_hazard_ctrl_ex2mem_rd_en_i,
               id_hazard_ctrl_ex2mem_load_i, id_hazard_ctrl_ex2mem_rd_index_i,
               id_hazard_ctrl_mem2wb_valid_i, id_hazard_ctrl_mem_busy_i,
        output id_hazard_ctrl_pc_stall_o, id_hazard_ctrl_if2id_stall_o,
               id_hazard_ctrl_if2id_flush_o, id_hazard_ctrl_id2ex_bubble_o,
               id_hazard_ctrl_freeze_o, id_hazard_ctrl_trap_redirect_o,
               id_hazard_ctrl_trap_type_o, id_hazard_ctrl_stall_cnt_o
    );
endinterface

// File: rtl/id_hazard_cmp.sv
// rtl/id_hazard_cmp.sv - register dependency comparator for one rs/producer pair
//
// Purpose: flags that a decode-stage source register is written by a live
//          producer further down the pipe. x0 is hardwired, never a dependency.
// Ports:   rs_en_i/rs_index_i           - consumer source register
//          prod_valid_i/prod_rd_en_i/
//          prod_rd_index_i              - producer stage register state
//          dep_o                        - dependency present
module id_hazard_cmp #(
    parameter int IDX_W = 5
) (
    input  logic             rs_en_i,
    input  logic [IDX_W-1:0] rs_index_i,
    input  logic             prod_valid_i,
    input  logic             prod_rd_en_i,
    input  logic [IDX_W-1:0] prod_rd_index_i,
    output logic             dep_o
);
    assign dep_o = rs_en_i && prod_valid_i && prod_rd_en_i
                && (rs_index_i != '0) && (rs_index_i == prod_rd_index_i);
endmodule

// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - five-stage pipeline hazard, flush and trap sequencing control
//
// Purpose: derives per-stage stall/flush/bubble/freeze strobes from decode
//          register usage and downstream stage state, drains the pipe before
//          a trap redirect, and counts stalled cycles.
// Ports:   clk, rst - core clock, asynchronous active-high reset
//          bus      - id_hazard_ctrl_if.slave: status inputs, control outputs
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int IDX_W = 5,
    parameter int CNT_W = 64
) (
    input  logic           clk,
    input  logic           rst,
    id_hazard_ctrl_if.slave bus
);
    logic dep_rs1_ex, dep_rs2_ex, dep_rs1_mem, dep_rs2_mem;
    logic dep_ex, dep_mem, hz;

    state_e           state_q, state_d;
    logic [1:0]       trap_type_q, trap_type_d;
    logic [CNT_W-1:0] cnt_q;
    ctrl_t            ctl;

    id_hazard_cmp #(.IDX_W(IDX_W)) u_cmp_rs1_ex (
        .rs_en_i        (bus.id_hazard_ctrl_id_rs1_en_i),
        .rs_index_i     (bus.id_hazard_ctrl_id_rs1_index_i),
        .prod_valid_i   (bus.id_hazard_ctrl_id2ex_valid_i),
        .prod_rd_en_i   (bus.id_hazard_ctrl_id2ex_rd_en_i),
        .prod_rd_index_i(bus.id_hazard_ctrl_id2ex_rd_index_i),
        .dep_o          (dep_rs1_ex)
    );

    id_hazard_cmp #(.IDX_W(IDX_W)) u_cmp_rs2_ex (
        .rs_en_i        (bus.id_hazard_ctrl_id_rs2_en_i),
        .rs_index_i     (bus.id_hazard_ctrl_id_rs2_index_i),
        .prod_valid_i   (bus.id_hazard_ctrl_id2ex_valid_i),
        .prod_rd_en_i   (bus.id_hazard_ctrl_id2ex_rd_en_i),
        .prod_rd_index_i(bus.id_hazard_ctrl_id2ex_rd_index_i),
        .dep_o          (dep_rs2_ex)
    );

    id_hazard_cmp #(.IDX_W(IDX_W)) u_cmp_rs1_mem (
        .rs_en_i        (bus.id_hazard_ctrl_id_rs1_en_i),
        .rs_index_i     (bus.id_hazard_ctrl_id_rs1_index_i),
        .prod_valid_i   (bus.id_hazard_ctrl_ex2mem_valid_i),
        .prod_rd_en_i   (bus.id_hazard_ctrl_ex2mem_rd_en_i),
        .prod_rd_index_i(bus.id_hazard_ctrl_ex2mem_rd_index_i),
        .dep_o          (dep_rs1_mem)
    );

    id_hazard_cmp #(.IDX_W(IDX_W)) u_cmp_rs2_mem (
        .rs_en_i        (bus.id_hazard_ctrl_id_rs2_en_i),
        .rs_index_i     (bus.id_hazard_ctrl_id_rs2_index_i),
        .prod_valid_i   (bus.id_hazard_ctrl_ex2mem_valid_i),
        .prod_rd_en_i   (bus.id_hazard_ctrl_ex2mem_rd_en_i),
        .prod_rd_index_i(bus.id_hazard_ctrl_ex2mem_rd_index_i),
        .dep_o          (dep_rs2_mem)
    );

    assign dep_ex  = dep_rs1_ex  | dep_rs2_ex;
    assign dep_mem = dep_rs1_mem | dep_rs2_mem;

    // ALU results forward from EX, so only loads block ordinary consumers.
    // Branches resolve in ID and need their operands a stage earlier: any
    // EX producer, or a load still sitting in MEM.
    assign hz = bus.id_hazard_ctrl_id_valid_i &&
                ((bus.id_hazard_ctrl_id2ex_load_i && dep_ex) ||
                 (bus.id_hazard_ctrl_id_jb_i && dep_ex) ||
                 (bus.id_hazard_ctrl_id_jb_i && bus.id_hazard_ctrl_ex2mem_load_i && dep_mem));

    always_comb begin
        state_d     = state_q;
        trap_type_d = trap_type_q;
        ctl         = '0;
        if (bus.id_hazard_ctrl_mem_busy_i) begin
            ctl.freeze = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (hz) begin
                        ctl.pc_stall     = 1'b1;
                        ctl.if2id_stall  = 1'b1;
                        ctl.id2ex_bubble = 1'b1;
                    end else if (bus.id_hazard_ctrl_id_valid_i && bus.id_hazard_ctrl_id_trap_i) begin
                        // Trap stays parked in IF/ID; only a bubble goes down the pipe.
                        ctl.pc_stall     = 1'b1;
                        ctl.if2id_stall  = 1'b1;
                        ctl.id2ex_bubble = 1'b1;
                        trap_type_d      = bus.id_hazard_ctrl_id_trap_type_i;
                        state_d          = ST_DRAIN;
                    end else if (bus.id_hazard_ctrl_id_jb_taken_i) begin
                        ctl.if2id_flush = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    ctl.pc_stall     = 1'b1;
                    ctl.if2id_stall  = 1'b1;
                    ctl.id2ex_bubble = 1'b1;
                    if (!bus.id_hazard_ctrl_ex2mem_valid_i && !bus.id_hazard_ctrl_mem2wb_valid_i) begin
                        state_d = ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    ctl.trap_redirect = 1'b1;
                    ctl.if2id_flush   = 1'b1;
                    state_d           = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            trap_type_q <= TRAP_NONE;
        end else begin
            state_q     <= state_d;
            trap_type_q <= trap_type_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (ctl.pc_stall || ctl.freeze) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Controls go straight to the stage registers; hold them low during reset.
    assign bus.id_hazard_ctrl_pc_stall_o      = !rst && ctl.pc_stall;
    assign bus.id_hazard_ctrl_if2id_stall_o   = !rst && ctl.if2id_stall;
    assign bus.id_hazard_ctrl_if2id_flush_o   = !rst && ctl.if2id_flush;
    assign bus.id_hazard_ctrl_id2ex_bubble_o  = !rst && ctl.id2ex_bubble;
    assign bus.id_hazard_ctrl_freeze_o        = !rst && ctl.freeze;
    assign bus.id_hazard_ctrl_trap_redirect_o = !rst && ctl.trap_redirect;
    assign bus.id_hazard_ctrl_trap_type_o     = (!rst && ctl.trap_redirect) ? trap_type_q : TRAP_NONE;
    assign bus.id_hazard_ctrl_stall_cnt_o     = cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb/tb_id_hazard_ctrl.sv - scoreboard bench for id_hazard_ctrl
module tb_id_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    id_hazard_ctrl_if #(.IDX_W(5), .CNT_W(64)) bus ();

    id_hazard_ctrl #(.IDX_W(5), .CNT_W(64)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // {pc_stall, if2id_stall, flush, bubble, freeze, redirect, trap_type[1:0]}
    localparam logic [7:0] C_IDLE   = 8'b0000_0000;
    localparam logic [7:0] C_STALL  = 8'b1101_0000;
    localparam logic [7:0] C_FLUSH  = 8'b0010_0000;
    localparam logic [7:0] C_FREEZE = 8'b0000_1000;
    localparam logic [7:0] C_REDIR  = 8'b0010_0100;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] exp_cnt     = '0;
    logic [71:0] exp_q[$];
    string       tag_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic r1e, input logic [4:0] r1,
                          input logic r2e, input logic [4:0] r2, input logic jb,
                          input logic tk, input logic tr, input logic [1:0] tt);
        bus.id_hazard_ctrl_id_valid_i     = v;
        bus.id_hazard_ctrl_id_rs1_en_i    = r1e;
        bus.id_hazard_ctrl_id_rs1_index_i = r1;
        bus.id_hazard_ctrl_id_rs2_en_i    = r2e;
        bus.id_hazard_ctrl_id_rs2_index_i = r2;
        bus.id_hazard_ctrl_id_jb_i        = jb;
        bus.id_hazard_ctrl_id_jb_taken_i  = tk;
        bus.id_hazard_ctrl_id_trap_i      = tr;
        bus.id_hazard_ctrl_id_trap_type_i = tt;
    endtask

    task automatic set_ex(input logic v, input logic en, input logic ld, input logic [4:0] rd);
        bus.id_hazard_ctrl_id2ex_valid_i    = v;
        bus.id_hazard_ctrl_id2ex_rd_en_i    = en;
        bus.id_hazard_ctrl_id2ex_load_i     = ld;
        bus.id_hazard_ctrl_id2ex_rd_index_i = rd;
    endtask

    task automatic set_mem(input logic v, input logic en, input logic ld, input logic [4:0] rd);
        bus.id_hazard_ctrl_ex2mem_valid_i    = v;
        bus.id_hazard_ctrl_ex2mem_rd_en_i    = en;
        bus.id_hazard_ctrl_ex2mem_load_i     = ld;
        bus.id_hazard_ctrl_ex2mem_rd_index_i = rd;
    endtask

    task automatic set_wb(input logic v, input logic busy);
        bus.id_hazard_ctrl_mem2wb_valid_i = v;
        bus.id_hazard_ctrl_mem_busy_i     = busy;
    endtask

    task automatic clear_all();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_ex(0, 0, 0, 0);
        set_mem(0, 0, 0, 0);
        set_wb(0, 0);
    endtask

    // Push the expected controls and counter value for the cycle just driven.
    task automatic expect_v(input string tag, input logic [7:0] ctl);
        if (rst) exp_cnt = '0;
        exp_q.push_back({ctl, exp_cnt});
        tag_q.push_back(tag);
        if (!rst && (ctl[7] || ctl[3])) exp_cnt = exp_cnt + 64'd1;
    endtask

    initial begin : monitor
        logic [71:0] e;
        string       t;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                chk({t, ".ctl"},
                    {56'd0, bus.id_hazard_ctrl_pc_stall_o, bus.id_hazard_ctrl_if2id_stall_o,
                     bus.id_hazard_ctrl_if2id_flush_o, bus.id_hazard_ctrl_id2ex_bubble_o,
                     bus.id_hazard_ctrl_freeze_o, bus.id_hazard_ctrl_trap_redirect_o,
                     bus.id_hazard_ctrl_trap_type_o},
                    {56'd0, e[71:64]});
                chk({t, ".cnt"}, bus.id_hazard_ctrl_stall_cnt_o, e[63:0]);
            end
        end
    end

    initial begin : stim
        clear_all();

        // Reset held with a live load-use hazard present
        cyc(); set_id(1, 1, 5, 0, 0, 0, 0, 0, 0); set_ex(1, 1, 1, 5); expect_v("rst_hold", C_IDLE);
        cyc(); rst = 1'b0; clear_all(); expect_v("idle", C_IDLE);

        // Load-use: one stall cycle
        cyc(); set_id(1, 1, 5, 0, 0, 0, 0, 0, 0); set_ex(1, 1, 1, 5); expect_v("lu_stall", C_STALL);
        cyc(); set_ex(0, 0, 0, 0); set_mem(1, 1, 1, 5); expect_v("lu_go", C_IDLE);

        // Taken branch depending on a load: two stalls, flush held off until clear
        cyc(); set_id(1, 0, 0, 1, 7, 1, 1, 0, 0); set_ex(1, 1, 1, 7); set_mem(0, 0, 0, 0);
        expect_v("bl_stall0", C_STALL);
        cyc(); set_ex(0, 0, 0, 0); set_mem(1, 1, 1, 7); expect_v("bl_stall1", C_STALL);
        cyc(); set_mem(0, 0, 0, 0); set_wb(1, 0); expect_v("bl_go", C_FLUSH);

        // x0, disabled rs, disabled rd, invalid producer, invalid consumer
        cyc(); set_wb(0, 0); set_id(1, 1, 0, 1, 0, 1, 0, 0, 0); set_ex(1, 1, 1, 0); set_mem(1, 1, 1, 0);
        expect_v("idx0", C_IDLE);
        cyc(); set_id(1, 0, 9, 0, 9, 1, 0, 0, 0); set_ex(1, 1, 1, 9); set_mem(1, 1, 1, 9);
        expect_v("rs_dis", C_IDLE);
        cyc(); set_id(1, 1, 9, 1, 9, 1, 0, 0, 0); set_ex(1, 0, 1, 9); set_mem(1, 0, 1, 9);
        expect_v("rd_dis", C_IDLE);
        cyc(); set_ex(0, 1, 1, 9); set_mem(0, 1, 1, 9); expect_v("prod_inv", C_IDLE);
        cyc(); set_id(0, 1, 9, 1, 9, 1, 0, 0, 0); set_ex(1, 1, 1, 9); set_mem(1, 1, 1, 9);
        expect_v("id_inv", C_IDLE);

        // ALU producers: forwarded for ALU consumers, stall for branches in EX only
        cyc(); set_id(1, 1, 3, 0, 0, 0, 0, 0, 0); set_ex(1, 1, 0, 3); set_mem(0, 0, 0, 0);
        expect_v("alu_fwd", C_IDLE);
        cyc(); set_id(1, 0, 0, 1, 3, 1, 0, 0, 0); expect_v("br_alu", C_STALL);
        cyc(); set_ex(0, 0, 0, 0); set_mem(1, 1, 0, 3); expect_v("br_mem_alu", C_IDLE);

        // Taken jal, no hazard
        cyc(); set_id(1, 0, 0, 0, 0, 1, 1, 0, 0); set_mem(0, 0, 0, 0); expect_v("jal", C_FLUSH);
        cyc(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_v("jal_after", C_IDLE);

        // Freeze outranks a hazard
        cyc(); set_id(1, 1, 5, 0, 0, 0, 0, 0, 0); set_ex(1, 1, 1, 5); set_wb(0, 1); expect_v("frz_hz", C_FREEZE);
        cyc(); set_wb(0, 0); expect_v("frz_rel", C_STALL);

        // ecall with two older instructions in flight
        cyc(); set_id(1, 0, 0, 0, 0, 0, 0, 1, 2'b01); set_ex(1, 1, 0, 12); set_mem(1, 1, 0, 13);
        expect_v("ec_cap", C_STALL);
        cyc(); set_ex(0, 0, 0, 0); set_mem(1, 1, 0, 12); set_wb(1, 0); expect_v("ec_d0", C_STALL);
        cyc(); set_mem(0, 0, 0, 0); expect_v("ec_d1", C_STALL);
        cyc(); set_wb(0, 0); expect_v("ec_d2", C_STALL);
        cyc(); expect_v("ec_redir", C_REDIR | 8'h01);
        cyc(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_v("ec_run", C_IDLE);

        // ebreak with memory busy for three DRAIN cycles
        cyc(); set_id(1, 0, 0, 0, 0, 0, 0, 1, 2'b10); expect_v("eb_cap", C_STALL);
        for (int i = 0; i < 3; i++) begin
            cyc(); set_wb(0, 1); expect_v("eb_frz", C_FREEZE);
        end
        cyc(); set_wb(0, 0); expect_v("eb_d", C_STALL);
        cyc(); expect_v("eb_redir", C_REDIR | 8'h02);
        cyc(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_v("eb_run", C_IDLE);

        // mret waits out a hazard; busy during REDIRECT postpones the pulse
        cyc(); set_id(1, 1, 4, 0, 0, 0, 0, 1, 2'b11); set_ex(1, 1, 1, 4); expect_v("mr_hz", C_STALL);
        cyc(); set_ex(0, 0, 0, 0); expect_v("mr_cap", C_STALL);
        cyc(); expect_v("mr_d", C_STALL);
        cyc(); set_wb(0, 1); expect_v("mr_frz", C_FREEZE);
        cyc(); set_wb(0, 0); expect_v("mr_redir", C_REDIR | 8'h03);
        cyc(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_v("mr_run", C_IDLE);

        // Reset mid-DRAIN, then hazard detection resumes
        cyc(); set_id(1, 0, 0, 0, 0, 0, 0, 1, 2'b01); set_mem(1, 1, 0, 2); expect_v("rd_cap", C_STALL);
        cyc(); expect_v("rd_d", C_STALL);
        cyc(); rst = 1'b1; expect_v("rd_rst", C_IDLE);
        cyc(); rst = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_v("rd_run", C_IDLE);
        cyc(); set_mem(0, 0, 0, 0); set_id(1, 1, 5, 0, 0, 0, 0, 0, 0); set_ex(1, 1, 1, 5);
        expect_v("rd_lu", C_STALL);
        cyc(); clear_all(); expect_v("rd_cnt", C_IDLE);

        repeat (2) @(negedge clk);
        #3;
        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
